alu_seq_ctrl: RTL and testbench
===============================

ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 SHALL use one clock; reset is synchronous and active-high; ports named clk and reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 req_valid  input  1  operation request present.
REQ-005 req_ready  output  1  block can accept a request.
REQ-006 req_mul  input  1  1 = 64x64 multiply (low 64 bits), 0 = single ALU op.
REQ-007 req_cntrl  input  3  ALU op code when req_mul=0: 000 pass B, 010 add, 011 sub, 100 and, 101 or, 110 xor; 001/111 reserved.
REQ-008 req_a, req_b  input  64 each  operands.
REQ-009 req_setflags  input  1  update architectural flag register on completion.
REQ-010 rsp_valid  output  1  response present.
REQ-011 rsp_ready  input  1  consumer accepts response.
REQ-012 rsp_result  output  64  result.
REQ-013 rsp_negative, rsp_zero, rsp_overflow, rsp_carry_out  output  1 each  result flags.
REQ-014 rsp_err  output  1  request used a reserved code.
REQ-015 flag_n, flag_z, flag_v, flag_c  output  1 each  architectural flag register.

Function
REQ-016 States SHALL be IDLE, EXEC, MUL, RESP; req_ready=1 only in IDLE.
REQ-017 Accept = req_valid & req_ready; operands, op, setflags SHALL be registered at accept; IDLE->MUL if req_mul, else IDLE->EXEC.
REQ-018 EXEC SHALL drive the ALU one cycle with registered operands/cntrl, capture result and ALU flags, go to RESP; rsp_valid asserts the cycle after EXEC (accept cycle 0 -> rsp_valid cycle 2).
REQ-019 Reserved cntrl in EXEC SHALL yield result 0, all four rsp flags 0, rsp_err=1.
REQ-020 MUL SHALL run exactly 64 iterations: acc init 0, m=A, q=B; each cycle ALU add(acc, q[0]?m:0) -> acc, m<<=1, q>>=1 (logical); after iteration 64 go to RESP (rsp_valid cycle 66 after accept cycle 0).
REQ-021 MUL response: result=acc, negative=acc[63], zero=(acc==0), overflow=0, carry_out=0, err=0; signed and unsigned low halves identical.
REQ-022 In RESP, rsp_valid=1 and all rsp_* SHALL hold stable until rsp_valid & rsp_ready; then next state IDLE.
REQ-023 On response handshake with setflags=1 and err=0, flag_n/z/v/c SHALL load rsp_negative/zero/overflow/carry_out; otherwise flags hold.
REQ-024 Requests SHALL NOT be accepted in EXEC, MUL, RESP; minimum spacing between accepts is 3 cycles (single op, rsp_ready tied 1).
REQ-025 rsp_* outputs SHALL be registered; no combinational path from req_* to rsp_*.

Reset
REQ-026 reset SHALL force IDLE, rsp_valid=0, rsp_result=0, all rsp flags and rsp_err=0, flag register=0, iteration counter=0, from the next edge.
REQ-027 Reset mid-EXEC/MUL/RESP SHALL abandon the operation with no response and no flag update.
REQ-028 reset SHALL override a simultaneous accept or response handshake.

Structure
REQ-029 Package alu_seq_pkg SHALL hold state enum, cntrl code constants (PASS_B, ADD, SUB, AND, OR, XOR) and MUL_ITERS=64.
REQ-030 Block SHALL instantiate exactly one existing alu module as its sole datapath adder; 7-bit iteration counter local.

Verification
REQ-031 ADD 0x7FFF_FFFF_FFFF_FFFF + 1, rsp_ready=1 -> cycle 2 result 0x8000_0000_0000_0000, N=1, Z=0, V=1, C=0.
REQ-032 SUB 5-5 setflags=1 -> result 0, Z=1, C=1, N=0, V=0; flag_z=1, flag_c=1 the cycle after handshake.
REQ-033 MUL 12345 x 678 -> cycle 66 result 8369910; MUL 0xFFFF_FFFF_FFFF_FFFF x 3 -> 0xFFFF_FFFF_FFFF_FFFD, N=1.
REQ-034 rsp_ready held 0 for 5 cycles after rsp_valid -> rsp_* unchanged, req_ready=0 throughout, IDLE the cycle after release.
REQ-035 reset asserted at MUL iteration 30 -> next cycle req_ready=1, rsp_valid=0, flags 0; no response emitted.
REQ-036 cntrl 001 with setflags=1 after flags set by REQ-032 -> rsp_err=1, result 0, flag_z=1/flag_c=1 retained.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the sequenced ALU controller: FSM states,
// ALU op codes, multiply iteration count and the registered response bundle.
package alu_seq_pkg;

  localparam int unsigned DATA_W    = 64;
  localparam int unsigned MUL_ITERS = 64;
  localparam int unsigned ITER_W    = 7;

  localparam logic [2:0] PASS_B = 3'b000;
  localparam logic [2:0] ADD    = 3'b010;
  localparam logic [2:0] SUB    = 3'b011;
  localparam logic [2:0] AND    = 3'b100;
  localparam logic [2:0] OR     = 3'b101;
  localparam logic [2:0] XOR    = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL  = 2'd2,
    RESP = 2'd3
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic              negative;
    logic              zero;
    logic              overflow;
    logic              carry_out;
    logic              err;
  } rsp_t;

  function automatic logic cntrl_reserved(input logic [2:0] cntrl);
    return !(cntrl inside {PASS_B, ADD, SUB, AND, OR, XOR});
  endfunction

endpackage

// File: rtl/alu_seq_ctrl_alu.sv
// Single-cycle 64-bit ALU (pass/add/sub/and/or/xor) with N/Z/V/C flags; purely combinational.
// No handshake: the controller owns all sequencing and holds operands stable.
module alu_seq_ctrl_alu
  import alu_seq_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        cntrl,
  output logic [DATA_W-1:0] result,
  output logic              negative,
  output logic              zero,
  output logic              overflow,
  output logic              carry_out
);

  logic              is_sub;
  logic [DATA_W-1:0] b_op;
  logic [DATA_W:0]   sum_ext;

  // Subtract is a + ~b + 1, so carry_out means "no borrow".
  always_comb begin
    is_sub  = (cntrl == SUB);
    b_op    = is_sub ? ~b : b;
    sum_ext = {1'b0, a} + {1'b0, b_op} + {{DATA_W{1'b0}}, is_sub};
  end

  always_comb begin
    result    = '0;
    overflow  = 1'b0;
    carry_out = 1'b0;
    case (cntrl)
      PASS_B: result = b;
      ADD, SUB: begin
        result    = sum_ext[DATA_W-1:0];
        overflow  = (a[DATA_W-1] == b_op[DATA_W-1]) && (sum_ext[DATA_W-1] != a[DATA_W-1]);
        carry_out = sum_ext[DATA_W];
      end
      AND:     result = a & b;
      OR:      result = a | b;
      XOR:     result = a ^ b;
      default: result = '0;
    endcase
    negative = result[DATA_W-1];
    zero     = (result == '0);
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequenced ALU: single ops respond 2 cycles after accept, 64x64 shift-add multiply after 66.
// One op in flight; req_ready only in IDLE; response held stable until rsp_ready.
module alu_seq_ctrl
  import alu_seq_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_mul,
  input  logic [2:0]        req_cntrl,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic              req_setflags,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_negative,
  output logic              rsp_zero,
  output logic              rsp_overflow,
  output logic              rsp_carry_out,
  output logic              rsp_err,
  output logic              flag_n,
  output logic              flag_z,
  output logic              flag_v,
  output logic              flag_c
);

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [2:0]        op_cntrl;
  logic              op_setflags;
  logic [DATA_W-1:0] acc;
  logic [ITER_W-1:0] iter_cnt;
  rsp_t              rsp_q;
  logic [3:0]        flags_q;

  logic              accept;
  logic              rsp_fire;
  logic              mul_done;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [2:0]        alu_cntrl;
  logic [DATA_W-1:0] alu_result;
  logic              alu_n;
  logic              alu_z;
  logic              alu_v;
  logic              alu_c;

  assign accept   = req_valid & req_ready;
  assign rsp_fire = rsp_valid & rsp_ready;
  assign mul_done = (iter_cnt == ITER_W'(MUL_ITERS));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = req_mul ? MUL : EXEC;
      EXEC:    state_nxt = RESP;
      MUL:     if (mul_done) state_nxt = RESP;
      RESP:    if (rsp_fire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE:    req_ready = 1'b1;
      RESP:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // The one adder is shared: during MUL it accumulates the shifted multiplicand.
  always_comb begin
    alu_a     = op_a;
    alu_b     = op_b;
    alu_cntrl = op_cntrl;
    if (state == MUL) begin
      alu_a     = acc;
      alu_b     = op_b[0] ? op_a : '0;
      alu_cntrl = ADD;
    end
  end

  alu_seq_ctrl_alu u_alu (
    .a         (alu_a),
    .b         (alu_b),
    .cntrl     (alu_cntrl),
    .result    (alu_result),
    .negative  (alu_n),
    .zero      (alu_z),
    .overflow  (alu_v),
    .carry_out (alu_c)
  );

  // Operand capture and multiply iteration: op_a/op_b double as m/q.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_a        <= '0;
      op_b        <= '0;
      op_cntrl    <= PASS_B;
      op_setflags <= 1'b0;
      acc         <= '0;
      iter_cnt    <= '0;
    end else if (accept) begin
      op_a        <= req_a;
      op_b        <= req_b;
      op_cntrl    <= req_cntrl;
      op_setflags <= req_setflags;
      acc         <= '0;
      iter_cnt    <= '0;
    end else if (state == MUL && !mul_done) begin
      acc      <= alu_result;
      op_a     <= op_a << 1;
      op_b     <= op_b >> 1;
      iter_cnt <= iter_cnt + ITER_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_q <= '0;
    end else if (state == EXEC) begin
      if (cntrl_reserved(op_cntrl)) begin
        rsp_q     <= '0;
        rsp_q.err <= 1'b1;
      end else begin
        rsp_q.result    <= alu_result;
        rsp_q.negative  <= alu_n;
        rsp_q.zero      <= alu_z;
        rsp_q.overflow  <= alu_v;
        rsp_q.carry_out <= alu_c;
        rsp_q.err       <= 1'b0;
      end
    end else if (state == MUL && mul_done) begin
      rsp_q.result    <= acc;
      rsp_q.negative  <= acc[DATA_W-1];
      rsp_q.zero      <= (acc == '0);
      rsp_q.overflow  <= 1'b0;
      rsp_q.carry_out <= 1'b0;
      rsp_q.err       <= 1'b0;
    end
  end

  // Architectural flags commit only when the response is actually consumed.
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= '0;
    end else if (rsp_fire && op_setflags && !rsp_q.err) begin
      flags_q <= {rsp_q.negative, rsp_q.zero, rsp_q.overflow, rsp_q.carry_out};
    end
  end

  assign rsp_result    = rsp_q.result;
  assign rsp_negative  = rsp_q.negative;
  assign rsp_zero      = rsp_q.zero;
  assign rsp_overflow  = rsp_q.overflow;
  assign rsp_carry_out = rsp_q.carry_out;
  assign rsp_err       = rsp_q.err;
  assign {flag_n, flag_z, flag_v, flag_c} = flags_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl: expected responses queued at issue, checked by a monitor.
module tb_alu_seq_ctrl;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_mul;
  logic [2:0]  req_cntrl;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic        req_setflags;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_result;
  logic        rsp_negative;
  logic        rsp_zero;
  logic        rsp_overflow;
  logic        rsp_carry_out;
  logic        rsp_err;
  logic        flag_n;
  logic        flag_z;
  logic        flag_v;
  logic        flag_c;

  alu_seq_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_mul       (req_mul),
    .req_cntrl     (req_cntrl),
    .req_a         (req_a),
    .req_b         (req_b),
    .req_setflags  (req_setflags),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_result    (rsp_result),
    .rsp_negative  (rsp_negative),
    .rsp_zero      (rsp_zero),
    .rsp_overflow  (rsp_overflow),
    .rsp_carry_out (rsp_carry_out),
    .rsp_err       (rsp_err),
    .flag_n        (flag_n),
    .flag_z        (flag_z),
    .flag_v        (flag_v),
    .flag_c        (flag_c)
  );

  typedef struct {
    logic [63:0] result;
    logic [4:0]  flags;   // {n, z, v, c, err}
    int          lat;
    int          acc_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  bit   prev_vld = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: first valid cycle checks latency and payload; handshake re-checks and pops.
  always @(negedge clk) begin
    if (reset) begin
      prev_vld = 0;
    end else if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rsp actual=result %h required=no response", rsp_result);
      end else begin
        if (!prev_vld) begin
          chk("latency", 64'(cyc - exp_q[0].acc_cyc), 64'(exp_q[0].lat));
          chk("result", rsp_result, exp_q[0].result);
          chk("rsp_flags", 64'({rsp_negative, rsp_zero, rsp_overflow, rsp_carry_out, rsp_err}),
              64'(exp_q[0].flags));
        end
        if (rsp_ready) begin
          chk("result_hs", rsp_result, exp_q[0].result);
          chk("rsp_flags_hs", 64'({rsp_negative, rsp_zero, rsp_overflow, rsp_carry_out, rsp_err}),
              64'(exp_q[0].flags));
          void'(exp_q.pop_front());
        end
      end
      prev_vld = rsp_valid & !rsp_ready;
    end else begin
      prev_vld = 0;
    end
  end

  task automatic issue(input bit mul, input logic [2:0] cntrl, input logic [63:0] a,
                       input logic [63:0] b, input bit setflags, input bit track,
                       input logic [63:0] er, input logic [4:0] ef);
    exp_t e;
    int   n = 0;
    while (!req_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) chk("req_ready_timeout", 64'(req_ready), 64'd1);
    req_valid    = 1'b1;
    req_mul      = mul;
    req_cntrl    = cntrl;
    req_a        = a;
    req_b        = b;
    req_setflags = setflags;
    if (track) begin
      e.result  = er;
      e.flags   = ef;
      e.lat     = mul ? 66 : 2;
      e.acc_cyc = cyc;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_a     = '0;
    req_b     = '0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_pending", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    reset        = 1'b1;
    req_valid    = 1'b0;
    req_mul      = 1'b0;
    req_cntrl    = 3'b000;
    req_a        = '0;
    req_b        = '0;
    req_setflags = 1'b0;
    rsp_ready    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_result", rsp_result, 64'd0);
    chk("rst_flags", 64'({flag_n, flag_z, flag_v, flag_c, rsp_err}), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Signed overflow on add, no flag update
    issue(0, 3'b010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 0, 1, 64'h8000_0000_0000_0000, 5'b10100);
    chk("accepted_not_ready", 64'(req_ready), 64'd0);
    drain();
    chk("flags_untouched", 64'({flag_n, flag_z, flag_v, flag_c}), 64'd0);

    // SUB 5-5 sets Z and C, committed to flag register
    issue(0, 3'b011, 64'd5, 64'd5, 1, 1, 64'd0, 5'b01010);
    drain();
    chk("flags_after_sub", 64'({flag_n, flag_z, flag_v, flag_c}), 64'b0101);
    chk("idle_after_hs", 64'(req_ready), 64'd1);

    // Reserved codes: error response, flags retained
    issue(0, 3'b001, 64'd9, 64'd7, 1, 1, 64'd0, 5'b00001);
    drain();
    chk("flags_kept_reserved", 64'({flag_n, flag_z, flag_v, flag_c}), 64'b0101);
    issue(0, 3'b111, 64'd9, 64'd7, 0, 1, 64'd0, 5'b00001);
    drain();

    // Remaining add/sub boundaries
    issue(0, 3'b010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0, 1, 64'd0, 5'b01010);
    drain();
    issue(0, 3'b011, 64'd3, 64'd5, 0, 1, 64'hFFFF_FFFF_FFFF_FFFE, 5'b10000);
    drain();
    issue(0, 3'b011, 64'h8000_0000_0000_0000, 64'd1, 0, 1, 64'h7FFF_FFFF_FFFF_FFFF, 5'b00110);
    drain();

    // Multiply
    issue(1, 3'b000, 64'd12345, 64'd678, 0, 1, 64'd8369910, 5'b00000);
    drain();
    issue(1, 3'b000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 1, 1, 64'hFFFF_FFFF_FFFF_FFFD, 5'b10000);
    drain();
    chk("flags_after_mul", 64'({flag_n, flag_z, flag_v, flag_c}), 64'b1000);

    // Backpressure: hold response for 5 cycles
    rsp_ready = 1'b0;
    issue(0, 3'b010, 64'd1, 64'd2, 0, 1, 64'd3, 5'b00000);
    begin
      int n = 0;
      while (!rsp_valid && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
    end
    for (int i = 0; i < 5; i++) begin
      chk("hold_req_ready", 64'(req_ready), 64'd0);
      chk("hold_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("hold_result", rsp_result, 64'd3);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("idle_after_release", 64'(req_ready), 64'd1);
    drain();

    // Reset partway through a multiply: abandoned, no response
    issue(1, 3'b000, 64'd3, 64'd5, 1, 0, 64'd0, 5'b00000);
    repeat (29) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mulrst_req_ready", 64'(req_ready), 64'd1);
    chk("mulrst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("mulrst_result", rsp_result, 64'd0);
    chk("mulrst_flags", 64'({flag_n, flag_z, flag_v, flag_c}), 64'd0);
    repeat (80) @(posedge clk);
    #1;
    chk("mulrst_no_rsp", 64'(rsp_valid), 64'd0);

    // Logic ops and pass-through after recovery
    issue(0, 3'b100, 64'hFF00_FF00_FF00_FF00, 64'h0F0F_0F0F_0F0F_0F0F, 0, 1,
          64'h0F00_0F00_0F00_0F00, 5'b00000);
    drain();
    issue(0, 3'b101, 64'hFF00_FF00_FF00_FF00, 64'h0F0F_0F0F_0F0F_0F0F, 0, 1,
          64'hFF0F_FF0F_FF0F_FF0F, 5'b10000);
    drain();
    issue(0, 3'b110, 64'hFF00_FF00_FF00_FF00, 64'h0F0F_0F0F_0F0F_0F0F, 1, 1,
          64'hF00F_F00F_F00F_F00F, 5'b10000);
    drain();
    chk("flags_after_xor", 64'({flag_n, flag_z, flag_v, flag_c}), 64'b1000);
    issue(0, 3'b000, 64'h1234, 64'd0, 0, 1, 64'd0, 5'b01000);
    drain();

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
